// File: rtl/ramb4_s4_word_master.sv
// ramb4_s4_word_master
// Host-side initiator for a 1024x4 single-port block RAM. Each 16-bit word
// request becomes NIBBLES nibble accesses, least-significant nibble first.
// Read nibbles come back on the RAM's registered DO one cycle after each
// enable and are reassembled here. All RAM-facing outputs are registered.
// Optional feature macro: RAMB4_WORD_MASTER_CLEAR_EN. When it is defined,
// the whole RAM is zeroed after reset before the first request is accepted.

module ramb4_s4_word_master #(
  parameter int NIBBLES = 4,
  parameter int RAM_AW  = 10,
  localparam int NB_W    = $clog2(NIBBLES),
  localparam int WORD_W  = 4 * NIBBLES,
  localparam int WADDR_W = RAM_AW - NB_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  output logic               resp_valid,
  output logic [WORD_W-1:0]  resp_rdata,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [3:0]         ram_di,
  output logic               ram_en,
  output logic               ram_we,
  input  logic [3:0]         ram_do
);

`ifdef RAMB4_WORD_MASTER_CLEAR_EN
  localparam logic [2:0] S_CLEAR = 3'd0;
`endif
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

`ifdef RAMB4_WORD_MASTER_CLEAR_EN
  localparam logic [2:0] S_RESET = S_CLEAR;
`else
  localparam logic [2:0] S_RESET = S_IDLE;
`endif

  localparam logic [NB_W-1:0] LAST_NIB = NB_W'(NIBBLES - 1);

  logic [2:0]         state;
  logic [NB_W-1:0]    cnt;
  logic [NB_W-1:0]    cntNxt;
  logic [NB_W-1:0]    cntPrev;
  logic [WADDR_W-1:0] addrQ;
  logic [WORD_W-1:0]  wdataQ;
  logic [WORD_W-1:0]  rbuf;
  logic [WORD_W-1:0]  rfinal;

  // Neighbouring nibble indices, and the read word completed by the nibble now on DO
  always_comb begin
    cntNxt  = cnt + NB_W'(1);
    cntPrev = cnt - NB_W'(1);
    rfinal  = rbuf;
    rfinal[4*cnt +: 4] = ram_do;
  end

  // Request sequencing, nibble serialization and read reassembly
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_RESET;
      cnt        <= '0;
      addrQ      <= '0;
      wdataQ     <= '0;
      rbuf       <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      ram_addr   <= '0;
      ram_di     <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
`ifdef RAMB4_WORD_MASTER_CLEAR_EN
        S_CLEAR: begin
          if (!ram_en) begin
            ram_en   <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= '0;
            ram_di   <= 4'h0;
          end else if (ram_addr == {RAM_AW{1'b1}}) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            state  <= S_IDLE;
          end else begin
            ram_addr <= ram_addr + RAM_AW'(1);
          end
        end
`endif
        S_IDLE: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          if (req_valid && req_ready) begin
            addrQ     <= req_addr;
            wdataQ    <= req_wdata;
            cnt       <= '0;
            req_ready <= 1'b0;
            ram_en    <= 1'b1;
            ram_we    <= req_we;
            ram_addr  <= {req_addr, NB_W'(0)};
            ram_di    <= req_wdata[3:0];
            state     <= req_we ? S_WRITE : S_READ;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WRITE: begin
          if (cnt == LAST_NIB) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt      <= cntNxt;
            ram_addr <= {addrQ, cntNxt};
            ram_di   <= wdataQ[4*cntNxt +: 4];
          end
        end
        S_READ: begin
          if (cnt != '0) begin
            rbuf[4*cntPrev +: 4] <= ram_do;
          end
          if (cnt == LAST_NIB) begin
            ram_en <= 1'b0;
            state  <= S_DRAIN;
          end else begin
            cnt      <= cntNxt;
            ram_addr <= {addrQ, cntNxt};
          end
        end
        S_DRAIN: begin
          rbuf       <= rfinal;
          resp_rdata <= rfinal;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramb4_s4_word_master.sv
// tb_ramb4_s4_word_master
// Drives ramb4_s4_word_master against a behavioural 1024x4 RAM and compares
// cycle timing and read data with a word-level memory model.
// Optional feature macro: RAMB4_WORD_MASTER_CLEAR_EN (zeroing sweep after reset).

module tb_ramb4_s4_word_master;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_di;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_do;

  int compared;
  int mismatched;
  int acc0Total;

  logic [3:0]  ramMem [0:1023];
  logic [15:0] model  [0:255];

  ramb4_s4_word_master dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_en(ram_en), .ram_we(ram_we),
    .ram_do(ram_do)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Power-up contents of the RAM, used by both the RAM and the word model
  function automatic logic [3:0] initNib(input int i);
    return 4'((i * 5 + (i >> 3) + 9) & 15);
  endfunction

  // Behavioural block RAM with registered DO, plus a count of accesses to address 0
  initial begin
    for (int i = 0; i < 1024; i++) ramMem[i] <= initNib(i);
    ram_do    <= 4'h0;
    acc0Total <= 0;
    forever begin
      @(posedge CLK);
      if (ram_en) begin
        if (ram_we) ramMem[ram_addr] <= ram_di;
        else        ram_do <= ramMem[ram_addr];
        if (ram_addr == 10'd0) acc0Total <= acc0Total + 1;
      end
    end
  end

  // Safety net so a stuck run still ends
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("ready_timeout", req_ready, 1);
  endtask

  task automatic clearModel();
    for (int w = 0; w < 256; w++) model[w] = 16'h0000;
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] a, input logic [15:0] d);
    waitReady();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_wdata = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      checkOutput("nib_en", ram_en, 1);
      checkOutput("nib_we", ram_we, {31'd0, we});
      checkOutput("nib_addr", ram_addr, {a, k[1:0]});
      if (we) checkOutput("nib_di", ram_di, 32'((d >> (4 * k)) & 16'hF));
      checkOutput("nib_busy", req_ready, 0);
      tick();
    end
    if (we) begin
      checkOutput("wr_ready", req_ready, 1);
      checkOutput("wr_idle_en", ram_en, 0);
      checkOutput("wr_no_resp", resp_valid, 0);
      model[a] = d;
    end else begin
      checkOutput("rd_drain_en", ram_en, 0);
      checkOutput("rd_drain_resp", resp_valid, 0);
      checkOutput("rd_drain_busy", req_ready, 0);
      tick();
      checkOutput("rd_resp_valid", resp_valid, 1);
      checkOutput("rd_resp_ready", req_ready, 1);
      checkOutput("rd_rdata", resp_rdata, model[a]);
      tick();
      checkOutput("rd_resp_pulse", resp_valid, 0);
      checkOutput("rd_rdata_hold", resp_rdata, model[a]);
    end
  endtask

  // Linear directed sequence followed by randomized traffic
  initial begin
    int n;
    int acc0Before;
    logic [15:0] d;
    logic [15:0] old;
    logic [7:0]  a;
    compared   = 0;
    mismatched = 0;
    RST        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 16'h0000;
    for (int w = 0; w < 256; w++)
      model[w] = {initNib(4*w+3), initNib(4*w+2), initNib(4*w+1), initNib(4*w)};
`ifdef RAMB4_WORD_MASTER_CLEAR_EN
    clearModel();
`endif

    tick();
    tick();
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_rdata", resp_rdata, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_di", ram_di, 0);
    checkOutput("rst_ram_en", ram_en, 0);
    checkOutput("rst_ram_we", ram_we, 0);

    RST = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready !== 1'b1 && n < 3000);
`ifdef RAMB4_WORD_MASTER_CLEAR_EN
    checkOutput("clear_ready_delay", n, 1026);
`else
    checkOutput("ready_delay", n, 1);
`endif

    $display("[TB] write 0xBEEF to word 0x12 and read it back");
    applyStimulus(1'b1, 8'h12, 16'hBEEF);
    applyStimulus(1'b0, 8'h12, 16'h0000);

    $display("[TB] top word 0xFF stays inside 0x3FC..0x3FF");
    acc0Before = acc0Total;
    applyStimulus(1'b1, 8'hFF, 16'h1234);
    applyStimulus(1'b0, 8'hFF, 16'h0000);
    checkOutput("no_addr0_access", acc0Total - acc0Before, 0);

    $display("[TB] back-to-back read then write");
    waitReady();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h12;
    tick();
    req_we    = 1'b1;
    req_addr  = 8'h40;
    req_wdata = 16'hC3A5;
    for (int k = 0; k < 4; k++) begin
      checkOutput("b2b_rd_we", ram_we, 0);
      checkOutput("b2b_rd_addr", ram_addr, {8'h12, k[1:0]});
      tick();
    end
    checkOutput("b2b_drain_en", ram_en, 0);
    tick();
    checkOutput("b2b_resp_valid", resp_valid, 1);
    checkOutput("b2b_rdata", resp_rdata, model[8'h12]);
    checkOutput("b2b_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    checkOutput("b2b_wr_we", ram_we, 1);
    checkOutput("b2b_wr_addr", ram_addr, {8'h40, 2'd0});
    checkOutput("b2b_wr_di", ram_di, 4'h5);
    checkOutput("b2b_resp_pulse", resp_valid, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput("b2b_wr_addr_k", ram_addr, {8'h40, k[1:0]});
    end
    tick();
    checkOutput("b2b_wr_done", req_ready, 1);
    model[8'h40] = 16'hC3A5;
    applyStimulus(1'b0, 8'h40, 16'h0000);

    $display("[TB] reset in the middle of a write");
    a = 8'h5A;
    d = 16'($urandom);
    old = model[a];
    waitReady();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    checkOutput("mid_nib0_addr", ram_addr, {a, 2'd0});
    tick();
    checkOutput("mid_nib1_addr", ram_addr, {a, 2'd1});
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("mid_rst_en", ram_en, 0);
    checkOutput("mid_rst_we", ram_we, 0);
    checkOutput("mid_rst_ready", req_ready, 0);
    checkOutput("mid_rst_addr", ram_addr, 0);
    checkOutput("mid_rst_resp", resp_valid, 0);
`ifdef RAMB4_WORD_MASTER_CLEAR_EN
    clearModel();
`else
    model[a] = {old[15:8], d[7:0]};
    tick();
    checkOutput("mid_rel_ready", req_ready, 1);
`endif
    applyStimulus(1'b0, a, 16'h0000);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 255));
      if (i % 3 == 0) a = 8'h40;
      applyStimulus(1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    applyStimulus(1'b0, 8'h40, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
